// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler draining NUM_CH FIFOs into one stream.
// Bounded bursts per grant, 2-entry output buffer absorbs backpressure.
module fifo_rd_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int CHW       = 2,
  parameter int WIDTH     = 8,
  parameter int PTR       = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_rdempty,
  input  logic [NUM_CH*(PTR+1)-1:0] ch_rdusedw,
  input  logic [NUM_CH*WIDTH-1:0]   ch_dataout,
  output logic [NUM_CH-1:0]         ch_rden,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHW-1:0]            out_ch,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err_underrun
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    BURST
  } state_t;

  localparam logic [PTR:0] MB  = (PTR+1)'(MAX_BURST);
  localparam logic [PTR:0] ONE = (PTR+1)'(1);

  state_t         state, state_nx;
  logic [CHW-1:0] rr_ptr, gnt, arb_g;
  logic           arb_hit;
  logic [PTR:0]   remaining, arb_used, arb_len;

  logic           inflight, infl_last;
  logic [CHW-1:0] infl_ch;

  logic [WIDTH-1:0] buf_data [2];
  logic [CHW-1:0]   buf_ch   [2];
  logic             buf_last [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, occ;

  logic push, pop, credit;
  logic issue, underrun, rem_nz;

  always_comb begin
    arb_g   = '0;
    arb_hit = 1'b0;
    // descending scan so the nearest channel after rr_ptr wins
    for (int i = NUM_CH; i >= 1; i--) begin
      if (!ch_rdempty[(int'(rr_ptr) + i) % NUM_CH]) begin
        arb_hit = 1'b1;
        arb_g   = CHW'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  assign arb_used =
    ch_rdusedw[int'(arb_g)*(PTR+1) +: PTR+1];
  assign arb_len  = (arb_used < MB) ? arb_used : MB;

  assign push   = inflight;
  assign pop    = (count != 2'd0) & out_ready;
  assign occ    = count + {1'b0, inflight};
  // a word leaving this cycle frees its slot
  assign credit = (occ < 2'd2) | pop;

  assign rem_nz   = remaining != '0;
  assign underrun = (state == BURST) & rem_nz
                  & ch_rdempty[gnt];
  assign issue    = (state == BURST) & rem_nz
                  & credit & ~ch_rdempty[gnt]
                  & ~reset;

  assign ch_rden = issue
    ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt)
    : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (~&ch_rdempty) state_nx = ARB;
      ARB:
        state_nx = arb_hit ? BURST : IDLE;
      BURST:
        if (underrun || !rem_nz ||
            (issue && remaining == ONE))
          state_nx = ARB;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= CHW'(NUM_CH-1);
      gnt          <= '0;
      remaining    <= '0;
      inflight     <= 1'b0;
      infl_ch      <= '0;
      infl_last    <= 1'b0;
      err_underrun <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_ch[i]   <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      state        <= state_nx;
      err_underrun <= underrun;

      if (state == ARB && arb_hit) begin
        rr_ptr    <= arb_g;
        gnt       <= arb_g;
        remaining <= arb_len;
      end else if (underrun) begin
        remaining <= '0;
      end else if (issue) begin
        remaining <= remaining - ONE;
      end

      inflight <= issue;
      if (issue) begin
        infl_ch   <= gnt;
        infl_last <= remaining == ONE;
      end

      if (push) begin
        buf_data[wr_ptr] <=
          ch_dataout[int'(infl_ch)*WIDTH +: WIDTH];
        buf_ch[wr_ptr]   <= infl_ch;
        buf_last[wr_ptr] <= infl_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = count != 2'd0;
  assign out_data  = buf_data[rd_ptr];
  assign out_ch    = buf_ch[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign busy      = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: behavioural FIFOs,
// cycle-vector table plus directed stream sequences.
module tb_fifo_rd_arbiter;

  localparam int NUM_CH    = 4;
  localparam int CHW       = 2;
  localparam int WIDTH     = 8;
  localparam int PTR       = 4;
  localparam int MAX_BURST = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         ch_rdempty;
  logic [NUM_CH*(PTR+1)-1:0] ch_rdusedw;
  logic [NUM_CH*WIDTH-1:0]   ch_dataout;
  logic [NUM_CH-1:0]         ch_rden;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CHW-1:0]            out_ch;
  logic                      out_last;
  logic                      busy;
  logic                      err_underrun;

  fifo_rd_arbiter #(
    .NUM_CH(NUM_CH), .CHW(CHW), .WIDTH(WIDTH),
    .PTR(PTR), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_rdempty(ch_rdempty),
    .ch_rdusedw(ch_rdusedw),
    .ch_dataout(ch_dataout),
    .ch_rden(ch_rden),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_last(out_last),
    .busy(busy),
    .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  // behavioural show-ahead-off FIFOs
  logic [7:0] mem [4][16];
  int         head [4] = '{default: 0};
  int         tail [4] = '{default: 0};
  logic [7:0] dout [4] = '{default: 8'h00};
  logic [3:0] force_e = 4'h0;

  always @(posedge clk)
    for (int c = 0; c < 4; c++)
      if (ch_rden[c] && head[c] != tail[c]) begin
        dout[c] <= mem[c][head[c] % 16];
        head[c] <= head[c] + 1;
      end

  always_comb begin
    ch_rdempty = '0;
    ch_rdusedw = '0;
    ch_dataout = '0;
    for (int c = 0; c < 4; c++) begin
      ch_rdempty[c] = (tail[c] == head[c]) | force_e[c];
      ch_rdusedw[c*5 +: 5] = 5'(tail[c] - head[c]);
      ch_dataout[c*8 +: 8] = dout[c];
    end
  end

  logic [10:0] got_q [$];
  logic [10:0] exp_q [$];

  always @(negedge clk)
    if (out_valid && out_ready)
      got_q.push_back({out_ch, out_last, out_data});

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_word(input int c, input logic [7:0] d);
    mem[c][tail[c] % 16] = d;
    tail[c] = tail[c] + 1;
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++)
      push_word(c, 8'(16*c + k));
  endtask

  task automatic exp_w(input int c, input int k,
                       input logic last);
    exp_q.push_back({2'(c), last, 8'(16*c + k)});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    force_e = 4'h0;
    for (int c = 0; c < 4; c++) tail[c] = head[c];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string tag,
                              input int budget);
    int n;
    n = exp_q.size();
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (got_q.size() >= n) break;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size())
        chk($sformatf("%s_w%0d", tag, i),
            32'(got_q[i]), 32'(exp_q[i]));
  endtask

  typedef struct {
    logic       rdy;
    logic [3:0] rden;
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       bsy;
  } vec_t;

  vec_t tv [8];

  initial begin
    int n, bad, pls;
    logic ok;

    tv[0] = '{1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[2] = '{1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[3] = '{1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[4] = '{1'b1, 4'h1, 1'b1, 8'hA1, 1'b0, 1'b1};
    tv[5] = '{1'b1, 4'h0, 1'b1, 8'hB2, 1'b0, 1'b1};
    tv[6] = '{1'b1, 4'h0, 1'b1, 8'hC3, 1'b1, 1'b1};
    tv[7] = '{1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};

    // reset values, ch0 already loaded with A,B,C
    reset = 1'b1;
    out_ready = 1'b1;
    push_word(0, 8'hA1);
    push_word(0, 8'hB2);
    push_word(0, 8'hC3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rden", ch_rden, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", err_underrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_rden", i), ch_rden, tv[i].rden);
      chk($sformatf("v%0d_valid", i), out_valid, tv[i].vld);
      chk($sformatf("v%0d_busy", i), busy, tv[i].bsy);
      if (tv[i].vld) begin
        chk($sformatf("v%0d_data", i), out_data, tv[i].data);
        chk($sformatf("v%0d_ch", i), out_ch, 0);
        chk($sformatf("v%0d_last", i), out_last, tv[i].last);
      end
      @(posedge clk); #1;
    end

    // all channels full: 4-word bursts in 0,1,2,3 order
    do_reset();
    for (int c = 0; c < 4; c++) load(c, 6);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) exp_w(c, k, k == 3);
    for (int c = 0; c < 4; c++)
      for (int k = 4; k < 6; k++) exp_w(c, k, k == 5);
    check_stream("rr", 300);

    // backpressure: 5 stalled clocks mid-burst
    do_reset();
    load(1, 8);
    for (int k = 0; k < 8; k++) exp_w(1, k, k == 3 || k == 7);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (got_q.size() >= 2) break;
    end
    #1;
    out_ready = 1'b0;
    n = 0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ch_rden != 0) n++;
      if (!out_valid) ok = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    chk("stall_rden_le2", n <= 2, 1);
    chk("stall_valid_held", ok, 1);
    check_stream("bp", 100);

    // ch2 appears while ch1 is granted: served before ch0
    do_reset();
    load(0, 6);
    load(1, 2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ch_rden[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fair_ch1_grant", ok, 1);
    @(posedge clk); #1;
    load(2, 2);
    for (int k = 0; k < 4; k++) exp_w(0, k, k == 3);
    exp_w(1, 0, 1'b0);
    exp_w(1, 1, 1'b1);
    exp_w(2, 0, 1'b0);
    exp_w(2, 1, 1'b1);
    exp_w(0, 4, 1'b0);
    exp_w(0, 5, 1'b1);
    check_stream("fair", 100);

    // ch3 goes empty with 2 words of its burst left
    do_reset();
    load(3, 5);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ch_rden[3]) n++;
      if (n == 2) break;
    end
    chk("ur_two_issued", n, 2);
    @(posedge clk); #1;
    force_e[3] = 1'b1;
    pls = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (err_underrun) pls++;
      if (ch_rden != 0) bad++;
    end
    chk("ur_pulse_once", pls, 1);
    chk("ur_no_rden", bad, 0);
    chk("ur_idle_busy", busy, 0);
    @(posedge clk); #1;
    force_e[3] = 1'b0;
    exp_w(3, 0, 1'b0);
    exp_w(3, 1, 1'b0);
    exp_w(3, 2, 1'b0);
    exp_w(3, 3, 1'b0);
    exp_w(3, 4, 1'b1);
    check_stream("ur", 100);

    // reset with a word in flight
    do_reset();
    load(0, 6);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ch_rden[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mr_rden_seen", ok, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rden_gated", ch_rden, 0);
    for (int c = 0; c < 4; c++) tail[c] = head[c];
    @(negedge clk);
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rden", ch_rden, 0);
    @(posedge clk); #1;
    got_q.delete();
    reset = 1'b0;
    repeat (6) @(posedge clk);
    chk("mr_no_stale", got_q.size(), 0);
    chk("mr_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
